// File: rtl/row_filter3_pkg.sv
// Shared definitions for the row filter path: pixel width seen by the mat reader,
// the filter and the mat writer, plus the filter FSM state encoding.
package row_filter3_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/row_filter3_kernel.sv
// Combinational 1-2-1 horizontal kernel with round-half-up: (a + 2b + c + 2) >> 2.
module filt3_kernel
  import row_filter3_pkg::*;
#(
  parameter int DATA_W = PIX_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_c,
  output logic [DATA_W-1:0] o_y
);

  // Two guard bits hold 4*max+2, so the shifted result never exceeds the pixel range.
  logic [DATA_W+1:0] w_sum;

  assign w_sum = {2'b00, i_a} + {1'b0, i_b, 1'b0} + {2'b00, i_c} + (DATA_W+2)'(2);
  assign o_y   = w_sum[DATA_W+1:2];

endmodule

// File: rtl/row_filter3.sv
// Streaming 3-tap horizontal row filter with edge replication and a registered,
// back-pressurable output stage; counts fully emitted rows.
module row_filter3
  import row_filter3_pkg::*;
#(
  parameter int DATA_W = PIX_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_eol,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eol,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  row_count
);

  state_t            r_state;
  state_t            w_nstate;
  logic [DATA_W-1:0] r_prev;
  logic [DATA_W-1:0] r_cur;
  logic              r_vld_p1;
  logic [DATA_W-1:0] r_data_p1;
  logic              r_eol_p1;
  logic [CNT_W-1:0]  r_row_count;

  logic              w_out_free;
  logic              w_in_xfer;
  logic              w_tap_load;
  logic              w_tap_first;
  logic              w_out_load;
  logic              w_out_eol;
  logic              w_row_done;
  logic [DATA_W-1:0] w_c;
  logic [DATA_W-1:0] w_filt;

  assign w_out_free = !r_vld_p1 || out_ready;
  assign in_ready   = !rst && (r_state != ST_FLUSH) && w_out_free;
  assign w_in_xfer  = in_valid && in_ready;

  // In FLUSH the right neighbour of the last pixel is the pixel itself.
  assign w_c = (r_state == ST_FLUSH) ? r_cur : in_data;

  filt3_kernel #(.DATA_W(DATA_W)) u_kernel (
    .i_a (r_prev),
    .i_b (r_cur),
    .i_c (w_c),
    .o_y (w_filt)
  );

  always_comb begin
    w_nstate    = r_state;
    w_tap_load  = 1'b0;
    w_tap_first = 1'b0;
    w_out_load  = 1'b0;
    w_out_eol   = 1'b0;
    w_row_done  = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_tap_load  = 1'b1;
          w_tap_first = 1'b1;
          w_nstate    = in_eol ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_in_xfer) begin
          w_tap_load = 1'b1;
          w_out_load = 1'b1;
          w_nstate   = in_eol ? ST_FLUSH : ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (w_out_free) begin
          w_out_load = 1'b1;
          w_out_eol  = 1'b1;
          w_row_done = 1'b1;
          w_nstate   = ST_EMPTY;
        end
      end
      default: w_nstate = ST_EMPTY;
    endcase
  end

  // Stage p0 -> p1: tap update and output register load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_prev      <= '0;
      r_cur       <= '0;
      r_vld_p1    <= 1'b0;
      r_data_p1   <= '0;
      r_eol_p1    <= 1'b0;
      r_row_count <= '0;
    end else begin
      r_state <= w_nstate;
      if (w_tap_load) begin
        r_prev <= w_tap_first ? in_data : r_cur;
        r_cur  <= in_data;
      end
      if (w_out_load) begin
        r_vld_p1  <= 1'b1;
        r_data_p1 <= w_filt;
        r_eol_p1  <= w_out_eol;
      end else if (out_ready) begin
        r_vld_p1  <= 1'b0;
      end
      if (w_row_done) begin
        r_row_count <= r_row_count + CNT_W'(1);
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign out_data  = r_data_p1;
  assign out_eol   = r_eol_p1;
  assign row_count = r_row_count;

endmodule

// File: tb/tb_row_filter3.sv
// Scoreboard bench for row_filter3: stimulus pushes expected outputs, a forked
// monitor pops and compares on every output transfer.
module tb_row_filter3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_eol;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_eol;
  logic       out_ready;
  logic [7:0] row_count;

  int         n_tests = 0;
  int         n_fail  = 0;
  bit         rdy_rand = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  logic [7:0] pix[16];

  row_filter3 #(.DATA_W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_eol    (in_eol),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_eol   (out_eol),
    .out_ready (out_ready),
    .row_count (row_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    #1;
  endtask

  task automatic expect_px(input logic [7:0] d, input logic eol);
    exp_q.push_back({eol, d});
  endtask

  task automatic send(input logic [7:0] d, input logic eol);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_eol   = eol;
    do begin
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    in_valid = 1'b0;
    in_eol   = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: pixel %0d not accepted, expected accept within 200 cycles", d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick();
    tick();
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic send_row_1234();
    expect_px(8'd13, 1'b0);
    expect_px(8'd20, 1'b0);
    expect_px(8'd30, 1'b0);
    expect_px(8'd38, 1'b1);
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    send(8'd30, 1'b0);
    send(8'd40, 1'b1);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got data %0d eol %0d, expected no output", out_data, out_eol);
          end else begin
            mon_e = exp_q.pop_front();
            check("out_data", out_data, mon_e[7:0]);
            check("out_eol", out_eol, mon_e[8]);
          end
        end
      end
    join_none

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_eol    = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_eol", out_eol, 0);
    check("rst_row_count", row_count, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Basic row.
    send_row_1234();
    drain();
    check("row_count_1", row_count, 1);

    // Single-pixel row, then next row starts one cycle after the flush.
    expect_px(8'd100, 1'b1);
    send(8'd100, 1'b1);
    check("flush_in_ready", in_ready, 0);
    tick();
    check("after_flush_in_ready", in_ready, 1);
    expect_px(8'd53, 1'b0);
    expect_px(8'd58, 1'b1);
    send(8'd50, 1'b0);
    send(8'd60, 1'b1);

    // Saturated pixels.
    expect_px(8'd255, 1'b0);
    expect_px(8'd255, 1'b0);
    expect_px(8'd255, 1'b1);
    send(8'd255, 1'b0);
    send(8'd255, 1'b0);
    send(8'd255, 1'b1);
    drain();
    check("row_count_4", row_count, 4);

    // Back-pressure for 3 cycles while the first output is held.
    expect_px(8'd13, 1'b0);
    expect_px(8'd20, 1'b0);
    expect_px(8'd30, 1'b0);
    expect_px(8'd38, 1'b1);
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("stall_out_valid", out_valid, 1);
      check("stall_out_data", out_data, 13);
      check("stall_out_eol", out_eol, 0);
      check("stall_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    send(8'd30, 1'b0);
    send(8'd40, 1'b1);
    drain();
    check("row_count_5", row_count, 5);

    // Reset mid-row with an output pending.
    out_ready = 1'b0;
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 0);
    tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_row_count", row_count, 0);
    rst = 1'b0;
    #1;
    check("midrst_release_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send_row_1234();
    drain();
    check("row_count_after_rst", row_count, 1);

    // Random rows with random gaps and back-pressure; 255 more rows wrap the counter.
    rdy_rand = 1'b1;
    for (int r = 0; r < 255; r++) begin
      int len;
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) pix[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < len; i++) begin
        int l, c, rr;
        l  = (i == 0) ? pix[0] : pix[i-1];
        c  = pix[i];
        rr = (i == len - 1) ? pix[len-1] : pix[i+1];
        expect_px(8'((l + 2 * c + rr + 2) >> 2), (i == len - 1));
      end
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send(pix[i], (i == len - 1));
      end
    end
    rdy_rand  = 1'b0;
    out_ready = 1'b1;
    drain();
    check("row_count_wrap", row_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
